// File: rtl/mem_arbiter.sv
// Two-master arbiter for the shared processor-side memory port: one combinational
// issue stage, one registered response stage, round-robin or fixed priority.
module mem_arbiter #(
   parameter int AW         = 24,
   parameter int DW         = 12,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic [AW-1:0] m0_addr,
   input  logic          m0_we,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_ready,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic [AW-1:0] m1_addr,
   input  logic          m1_we,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_ready,
   output logic [DW-1:0] m1_rdata,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_wait
);

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RESP = 2'd1,
      HOLD = 2'd2
   } phase_t;

   logic   resp_valid;
   logic   resp_id;
   logic   last_grant;
   logic   resp_valid_nxt;
   logic   resp_id_nxt;
   logic   last_grant_nxt;
   phase_t phase;
   logic   elig0;
   logic   elig1;
   logic   grant;
   logic   grant_id;

   // HOLD depends on the live wait input, so the phase is decoded rather than stored.
   always_comb begin
      phase = IDLE;
      if (resp_valid) phase = mem_wait ? HOLD : RESP;
   end

   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      grant    = 1'b0;
      grant_id = M0;
      elig0    = m0_req && !(resp_valid && resp_id == M0);
      elig1    = m1_req && !(resp_valid && resp_id == M1);
      // rst gates the issue path too, so nothing reaches the bus while reset is held.
      if (rst && phase != HOLD) begin
         if (elig0 && elig1) begin
            grant    = 1'b1;
            grant_id = FIXED_PRIO ? M0 : ~last_grant;
         end else if (elig0) begin
            grant    = 1'b1;
            grant_id = M0;
         end else if (elig1) begin
            grant    = 1'b1;
            grant_id = M1;
         end
      end
   end

   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (grant) begin
         if (grant_id == M1) begin
            mem_addr  = m1_addr;
            mem_we    = m1_we;
            mem_wdata = m1_wdata;
         end else begin
            mem_addr  = m0_addr;
            mem_we    = m0_we;
            mem_wdata = m0_wdata;
         end
      end
   end

   always_comb begin
      resp_valid_nxt = 1'b0;
      resp_id_nxt    = resp_id;
      last_grant_nxt = last_grant;
      case (phase)
         HOLD: begin
            resp_valid_nxt = 1'b1;
         end
         default: begin
            if (grant) begin
               resp_valid_nxt = 1'b1;
               resp_id_nxt    = grant_id;
               last_grant_nxt = grant_id;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         resp_valid <= 1'b0;
         resp_id    <= M0;
         last_grant <= M1;
      end else begin
         // NOTE: non-blocking assignments so all state updates see pre-edge values.
         resp_valid <= resp_valid_nxt;
         resp_id    <= resp_id_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   assign m0_ready = (phase == RESP) && (resp_id == M0);
   assign m1_ready = (phase == RESP) && (resp_id == M1);
   assign m0_rdata = mem_rdata;
   assign m1_rdata = mem_rdata;

   a_ready_onehot : assert property (@(posedge clk) disable iff (!rst) !(m0_ready && m1_ready));
   a_hold_no_write : assert property (@(posedge clk) disable iff (!rst) !(phase == HOLD && mem_we));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: one round-robin and one fixed-priority
// instance, each driven by its own request queues and checked against a reference model.
module tb_mem_arbiter;

   localparam int AW = 24;
   localparam int DW = 12;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } req_t;

   typedef struct packed {
      logic          id;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] rdata;
   } exp_t;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          we;
      logic [DW-1:0] wdata;
      logic          rdy0;
      logic          rdy1;
      logic [DW-1:0] rdata0;
   } obs_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req       [2][2];
   logic [AW-1:0] addr      [2][2];
   logic          we        [2][2];
   logic [DW-1:0] wdata     [2][2];
   logic          rdy       [2][2];
   logic [DW-1:0] rdata     [2][2];
   logic [AW-1:0] mem_addr  [2];
   logic          mem_we    [2];
   logic [DW-1:0] mem_wdata [2];
   logic [DW-1:0] mem_rdata [2];
   logic          mem_wait  [2];

   req_t          pend       [2][2][$];
   exp_t          sb         [2][$];
   obs_t          log_q      [2][$];
   bit            wait_force [2][$];
   int            occ        [2];
   int            last       [2];
   bit            held       [2];
   logic [DW-1:0] next_rdata [2];
   int            wait_pct;
   bit            rand_on;
   int            n_checks;
   int            n_fail;
   int            cyc;

   mem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1'b0)) u_rr (
      .clk(clk), .rst(rst),
      .m0_req(req[0][0]), .m0_addr(addr[0][0]), .m0_we(we[0][0]), .m0_wdata(wdata[0][0]),
      .m0_ready(rdy[0][0]), .m0_rdata(rdata[0][0]),
      .m1_req(req[0][1]), .m1_addr(addr[0][1]), .m1_we(we[0][1]), .m1_wdata(wdata[0][1]),
      .m1_ready(rdy[0][1]), .m1_rdata(rdata[0][1]),
      .mem_addr(mem_addr[0]), .mem_we(mem_we[0]), .mem_wdata(mem_wdata[0]),
      .mem_rdata(mem_rdata[0]), .mem_wait(mem_wait[0])
   );

   mem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1'b1)) u_fp (
      .clk(clk), .rst(rst),
      .m0_req(req[1][0]), .m0_addr(addr[1][0]), .m0_we(we[1][0]), .m0_wdata(wdata[1][0]),
      .m0_ready(rdy[1][0]), .m0_rdata(rdata[1][0]),
      .m1_req(req[1][1]), .m1_addr(addr[1][1]), .m1_we(we[1][1]), .m1_wdata(wdata[1][1]),
      .m1_ready(rdy[1][1]), .m1_rdata(rdata[1][1]),
      .mem_addr(mem_addr[1]), .mem_we(mem_we[1]), .mem_wdata(mem_wdata[1]),
      .mem_rdata(mem_rdata[1]), .mem_wait(mem_wait[1])
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream memory contents are a fixed function of the address.
   function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
      return a[11:0] ^ a[23:12] ^ 12'hA9C;
   endfunction

   function automatic req_t rand_req();
      req_t r;
      r.we    = 1'($urandom_range(0, 1));
      r.addr  = AW'($urandom);
      r.wdata = DW'($urandom);
      return r;
   endfunction

   function automatic int pend_total();
      int n = 0;
      for (int i = 0; i < 2; i++)
         for (int m = 0; m < 2; m++) n += pend[i][m].size();
      return n;
   endfunction

   task automatic check(input string name, input int inst, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (inst %0d, cycle %0d): got 0x%0h, want 0x%0h", name, inst, cyc, act, exp);
      end
   endtask

   task automatic drive_all();
      req_t r;
      for (int i = 0; i < 2; i++) begin
         for (int m = 0; m < 2; m++) begin
            if (rand_on && pend[i][m].size() < 3 && $urandom_range(0, 99) < 40)
               pend[i][m].push_back(rand_req());
            if (pend[i][m].size() > 0) begin
               r           = pend[i][m][0];
               req[i][m]   = 1'b1;
               addr[i][m]  = r.addr;
               we[i][m]    = r.we;
               wdata[i][m] = r.wdata;
            end else begin
               req[i][m]   = 1'b0;
               addr[i][m]  = AW'($urandom);
               we[i][m]    = 1'($urandom_range(0, 1));
               wdata[i][m] = DW'($urandom);
            end
         end
         if (wait_force[i].size() > 0) mem_wait[i] = wait_force[i].pop_front();
         else mem_wait[i] = ($urandom_range(0, 99) < wait_pct);
         mem_rdata[i] = next_rdata[i];
      end
   endtask

   // Reference model: the response stage holds at most one transaction and its owner
   // may not issue again until it retires; a held stage blocks all issue.
   task automatic eval_inst(input int i);
      int   grant;
      int   exp_rdy;
      int   cand_n;
      int   cand;
      req_t r;
      exp_t e;
      obs_t o;
      grant   = -1;
      exp_rdy = -1;
      cand    = 0;
      cand_n  = 0;
      held[i] = 1'b0;
      o.addr   = mem_addr[i];
      o.we     = mem_we[i];
      o.wdata  = mem_wdata[i];
      o.rdy0   = rdy[i][0];
      o.rdy1   = rdy[i][1];
      o.rdata0 = rdata[i][0];
      log_q[i].push_back(o);
      if (!rst) begin
         occ[i]  = -1;
         last[i] = 1;
         sb[i].delete();
      end else begin
         held[i] = (occ[i] >= 0) && mem_wait[i];
         if (occ[i] >= 0 && !mem_wait[i]) exp_rdy = occ[i];
         for (int m = 0; m < 2; m++)
            if (pend[i][m].size() > 0 && m != occ[i]) begin
               cand_n++;
               cand = m;
            end
         if (!held[i]) begin
            if (cand_n == 2) grant = (i == 1) ? 0 : 1 - last[i];
            else if (cand_n == 1) grant = cand;
         end
      end
      check("m0_ready", i, rdy[i][0], exp_rdy == 0);
      check("m1_ready", i, rdy[i][1], exp_rdy == 1);
      if (grant >= 0) begin
         r = pend[i][grant][0];
         check("bus addr", i, mem_addr[i], r.addr);
         check("bus we", i, mem_we[i], r.we);
         check("bus wdata", i, mem_wdata[i], r.wdata);
         e.id    = grant[0];
         e.we    = r.we;
         e.addr  = r.addr;
         e.rdata = rd_fn(r.addr);
         sb[i].push_back(e);
      end else begin
         check("idle bus addr", i, mem_addr[i], 0);
         check("idle bus we", i, mem_we[i], 0);
         check("idle bus wdata", i, mem_wdata[i], 0);
      end
      if (!held[i]) next_rdata[i] = rd_fn(mem_addr[i]);
      if (exp_rdy >= 0) void'(pend[i][exp_rdy].pop_front());
      if (rst && !held[i]) occ[i] = grant;
      if (grant >= 0) last[i] = grant;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         drive_all();
         @(negedge clk);
         eval_inst(0);
         eval_inst(1);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_logs();
      for (int i = 0; i < 2; i++) log_q[i].delete();
   endtask

   task automatic push_both(input int m, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
      req_t r;
      r.we    = w;
      r.addr  = a;
      r.wdata = d;
      for (int i = 0; i < 2; i++) pend[i][m].push_back(r);
   endtask

   // Completion monitor: every ready retires the oldest outstanding issue.
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 2; i++)
         for (int m = 0; m < 2; m++)
            if (rdy[i][m] === 1'b1) begin
               if (sb[i].size() == 0) begin
                  check("ready with nothing in flight", i, 1, 0);
               end else begin
                  e = sb[i].pop_front();
                  check("ready master id", i, m, e.id);
                  if (!e.we) check("read data", i, rdata[i][m], e.rdata);
               end
            end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run did not complete (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      wait_pct = 0;
      rand_on  = 1'b0;
      for (int i = 0; i < 2; i++) begin
         occ[i]        = -1;
         last[i]       = 1;
         held[i]       = 1'b0;
         next_rdata[i] = '0;
      end
      drive_all();
      @(posedge clk);
      #1;
      run(2);

      // m0 read of 0o4000 right after reset release
      rst = 1'b1;
      clear_logs();
      push_both(0, 1'b0, 24'o4000, 12'o0);
      run(3);
      for (int i = 0; i < 2; i++) begin
         check("t1 issue addr", i, log_q[i][0].addr, 24'o4000);
         check("t1 issue we", i, log_q[i][0].we, 0);
         check("t1 no early ready", i, log_q[i][0].rdy0, 0);
         check("t1 m0_ready", i, log_q[i][1].rdy0, 1);
         check("t1 m0_rdata", i, log_q[i][1].rdata0, 12'o1234);
         check("t1 m1_ready quiet", i, log_q[i][1].rdy1, 0);
      end

      // both masters streaming from a fresh reset: strict alternation starting with m0
      rst = 1'b0;
      run(2);
      rst = 1'b1;
      clear_logs();
      for (int k = 0; k < 6; k++) begin
         push_both(0, 1'b0, AW'(24'h1000 + k), 12'h0);
         push_both(1, 1'b1, AW'(24'h2000 + k), DW'(k + 1));
      end
      run(14);
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 12; j++)
            check("t2 grant order", i, log_q[i][j].addr,
                  (j % 2 == 0) ? 24'h1000 + j / 2 : 24'h2000 + j / 2);
         for (int j = 1; j <= 12; j++) begin
            check("t2 m0_ready slot", i, log_q[i][j].rdy0, (j % 2 == 1) ? 1 : 0);
            check("t2 m1_ready slot", i, log_q[i][j].rdy1, (j % 2 == 0) ? 1 : 0);
         end
      end

      // conflict from idle after an m0 grant: round-robin favours m1, fixed favours m0
      push_both(0, 1'b0, 24'h4444, 12'h0);
      run(3);
      clear_logs();
      push_both(0, 1'b0, 24'h5000, 12'h0);
      push_both(1, 1'b0, 24'h6000, 12'h0);
      run(4);
      check("t3 rr first grant", 0, log_q[0][0].addr, 24'h6000);
      check("t3 rr second grant", 0, log_q[0][1].addr, 24'h5000);
      check("t3 fp first grant", 1, log_q[1][0].addr, 24'h5000);
      check("t3 fp second grant", 1, log_q[1][1].addr, 24'h6000);

      // m1 write held by mem_wait for three cycles, m0 arriving behind it
      clear_logs();
      push_both(1, 1'b1, 24'o100000, 12'o7777);
      for (int i = 0; i < 2; i++) begin
         wait_force[i].push_back(1'b0);
         repeat (3) wait_force[i].push_back(1'b1);
         wait_force[i].push_back(1'b0);
      end
      run(1);
      push_both(0, 1'b0, 24'h7000, 12'h0);
      run(7);
      for (int i = 0; i < 2; i++) begin
         check("t4 write addr", i, log_q[i][0].addr, 24'o100000);
         check("t4 write strobe", i, log_q[i][0].we, 1);
         check("t4 write data", i, log_q[i][0].wdata, 12'o7777);
         for (int j = 1; j <= 3; j++) begin
            check("t4 ready held low", i, log_q[i][j].rdy1, 0);
            check("t4 no write during hold", i, log_q[i][j].we, 0);
            check("t4 no issue during hold", i, log_q[i][j].addr, 0);
         end
         check("t4 m1_ready after wait", i, log_q[i][4].rdy1, 1);
         check("t4 m1_ready single pulse", i, log_q[i][5].rdy1, 0);
         check("t4 m0 issued on retire", i, log_q[i][4].addr, 24'h7000);
         check("t4 m0 completes", i, log_q[i][5].rdy0, 1);
      end

      // reset in the cycle after an m0 issue
      clear_logs();
      push_both(0, 1'b0, 24'h3333, 12'h0);
      run(1);
      rst = 1'b0;
      run(2);
      rst = 1'b1;
      run(3);
      for (int i = 0; i < 2; i++) begin
         check("t5 no ready in reset", i, log_q[i][1].rdy0, 0);
         check("t5 no write in reset", i, log_q[i][1].we, 0);
         check("t5 reissue addr", i, log_q[i][3].addr, 24'h3333);
         check("t5 reissue completes", i, log_q[i][4].rdy0, 1);
      end

      // ten idle cycles with random wait noise
      clear_logs();
      wait_pct = 50;
      run(10);
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 10; j++) begin
            check("t6 idle addr", i, log_q[i][j].addr, 0);
            check("t6 idle we", i, log_q[i][j].we, 0);
            check("t6 idle ready", i, {log_q[i][j].rdy1, log_q[i][j].rdy0}, 0);
         end

      // randomized traffic with random downstream wait
      wait_pct = 30;
      rand_on  = 1'b1;
      run(400);
      rand_on  = 1'b0;
      wait_pct = 0;
      for (int g = 0; g < 100 && pend_total() > 0; g++) run(1);
      run(2);
      for (int i = 0; i < 2; i++) begin
         check("requests drained", i, pend[i][0].size() + pend[i][1].size(), 0);
         check("scoreboard drained", i, sb[i].size(), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
